// File: rtl/melody_pkg.sv
// melody_pkg: shared constants for the melody sequencer.
//   - note codes (0 = rest, 1..8 = C4..C5)
//   - tone divisor table indexed by note code
//   - FSM state encoding
//   - song length and index/divisor widths
package melody_pkg;

   localparam int SONG_LEN = 42;
   localparam int IDX_W    = 6;
   // 19 bits: the largest divisor in the table (382225) does not fit in 18.
   localparam int DIV_W    = 19;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D4   = 4'd2;
   localparam logic [3:0] NOTE_E4   = 4'd3;
   localparam logic [3:0] NOTE_F4   = 4'd4;
   localparam logic [3:0] NOTE_G4   = 4'd5;
   localparam logic [3:0] NOTE_A4   = 4'd6;
   localparam logic [3:0] NOTE_B4   = 4'd7;
   localparam logic [3:0] NOTE_C5   = 4'd8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Clock cycles per full tone period for each note code; rest maps to 0.
   function automatic logic [DIV_W-1:0] note_divisor(input logic [3:0] code);
      case (code)
         NOTE_C4: note_divisor = 19'd382225;
         NOTE_D4: note_divisor = 19'd340524;
         NOTE_E4: note_divisor = 19'd303372;
         NOTE_F4: note_divisor = 19'd286345;
         NOTE_G4: note_divisor = 19'd255106;
         NOTE_A4: note_divisor = 19'd227272;
         NOTE_B4: note_divisor = 19'd202475;
         NOTE_C5: note_divisor = 19'd191112;
         default: note_divisor = '0;
      endcase
   endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// tone_gen: square-wave generator with a runtime divisor.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   en      - count enable; while low the counter and output are held at 0
//   divisor - tone period in clk cycles
//   tone    - registered square wave, high while counter < divisor/2
module tone_gen
   import melody_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] divisor,
   output logic             tone
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_tone;
   logic [DIV_W-1:0] w_half;

   assign w_half = divisor >> 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (!en) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else begin
         // Output reflects this cycle's count, so it lags the counter by one.
         r_tone <= (r_cnt < w_half);
         if (r_cnt >= divisor - DIV_W'(1))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + DIV_W'(1);
      end
   end

   assign tone = r_tone;

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 42-entry song as a square wave.
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   start     - pulse: begin playback at entry 0 (ignored while busy)
//   stop      - pulse: abort playback (wins over start)
//   loop_en   - sampled at the end of the last entry: wrap instead of finishing
//   tone_out  - square-wave audio
//   note_idx  - current song entry
//   note_code - note code of the current entry (0 in idle)
//   busy      - high while playing a note or its trailing gap
//   done      - one-cycle pulse when a non-looping song finishes
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int BEAT_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 5_000_000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
   output logic       tone_out,
   output logic [5:0] note_idx,
   output logic [3:0] note_code,
   output logic       busy,
   output logic       done
);

   localparam logic [26:0]      BEAT_LEN = 27'(BEAT_CYCLES);
   localparam logic [26:0]      GAP_LAST = 27'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

   logic [1:0]       r_state, w_state_next;
   logic [IDX_W-1:0] r_idx, w_idx_next;
   logic [26:0]      r_dur, w_dur_next;
   logic [3:0]       r_code;
   logic [1:0]       r_beats;
   logic             r_done, w_done_next;
   logic [3:0]       w_rom_code;
   logic [1:0]       w_rom_beats;
   logic [26:0]      w_play_len;
   logic             w_play_last;
   logic             w_load;
   logic             w_tone_en;
   logic             w_tone;

   // Song ROM (Twinkle verse), addressed by the entry about to be played.
   always_comb begin
      case (w_idx_next)
         6'd0, 6'd1, 6'd13, 6'd28, 6'd29, 6'd41:
            w_rom_code = NOTE_C4;
         6'd11, 6'd12, 6'd20, 6'd27, 6'd39, 6'd40:
            w_rom_code = NOTE_D4;
         6'd9, 6'd10, 6'd18, 6'd19, 6'd25, 6'd26, 6'd37, 6'd38:
            w_rom_code = NOTE_E4;
         6'd7, 6'd8, 6'd16, 6'd17, 6'd23, 6'd24, 6'd35, 6'd36:
            w_rom_code = NOTE_F4;
         6'd2, 6'd3, 6'd6, 6'd14, 6'd15, 6'd21, 6'd22, 6'd30, 6'd31, 6'd34:
            w_rom_code = NOTE_G4;
         6'd4, 6'd5, 6'd32, 6'd33:
            w_rom_code = NOTE_A4;
         default:
            w_rom_code = NOTE_REST;
      endcase
      case (w_idx_next)
         6'd6, 6'd13, 6'd20, 6'd27, 6'd34, 6'd41: w_rom_beats = 2'd2;
         default:                                 w_rom_beats = 2'd1;
      endcase
   end

   assign w_play_len  = {25'd0, r_beats} * BEAT_LEN;
   assign w_play_last = (r_dur == w_play_len - 27'd1);

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_dur_next   = r_dur;
      w_done_next  = 1'b0;
      if (stop) begin
         w_state_next = ST_IDLE;
         w_idx_next   = '0;
         w_dur_next   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_next = ST_PLAY;
                  w_idx_next   = '0;
                  w_dur_next   = '0;
               end
            end
            ST_PLAY: begin
               if (w_play_last) begin
                  w_state_next = ST_GAP;
                  w_dur_next   = '0;
               end else begin
                  w_dur_next = r_dur + 27'd1;
               end
            end
            ST_GAP: begin
               if (r_dur == GAP_LAST) begin
                  w_dur_next = '0;
                  if (r_idx != LAST_IDX) begin
                     w_state_next = ST_PLAY;
                     w_idx_next   = r_idx + IDX_W'(1);
                  end else if (loop_en) begin
                     w_state_next = ST_PLAY;
                     w_idx_next   = '0;
                  end else begin
                     w_state_next = ST_IDLE;
                     w_idx_next   = '0;
                     w_done_next  = 1'b1;
                  end
               end else begin
                  w_dur_next = r_dur + 27'd1;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_idx_next   = '0;
               w_dur_next   = '0;
            end
         endcase
      end
   end

   // Code and length are latched on PLAY entry so they stay stable through GAP.
   assign w_load = (w_state_next == ST_PLAY) && (r_state != ST_PLAY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_dur   <= '0;
         r_code  <= NOTE_REST;
         r_beats <= 2'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_dur   <= w_dur_next;
         r_done  <= w_done_next;
         if (w_load) begin
            r_code  <= w_rom_code;
            r_beats <= w_rom_beats;
         end else if (w_state_next == ST_IDLE) begin
            r_code  <= NOTE_REST;
            r_beats <= 2'd0;
         end
      end
   end

   // Enable drops on the last PLAY cycle (and on stop) so the registered tone
   // is already 0 on the first GAP/IDLE cycle; it also clears the counter so
   // every PLAY starts from 0.
   assign w_tone_en = (r_state == ST_PLAY) && (w_state_next == ST_PLAY) &&
                      (r_code != NOTE_REST);

   tone_gen u_tone (
      .clk     (clk),
      .rst     (rst),
      .en      (w_tone_en),
      .divisor (note_divisor(r_code)),
      .tone    (w_tone)
   );

   assign tone_out  = w_tone;
   assign note_idx  = r_idx;
   assign note_code = r_code;
   assign busy      = (r_state == ST_PLAY) || (r_state == ST_GAP);
   assign done      = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with short beat/gap timing.
// The reference model treats playback as a position on a song timeline:
// cycles since start, mapped to an entry via cumulative entry lengths.
module tb_melody_sequencer;

   localparam int BEAT = 20;
   localparam int GAP  = 4;
   localparam int N    = 42;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop_en = 1'b0;
   logic       tone_out;
   logic [5:0] note_idx;
   logic [3:0] note_code;
   logic       busy;
   logic       done;

   melody_sequencer #(
      .BEAT_CYCLES (BEAT),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .loop_en   (loop_en),
      .tone_out  (tone_out),
      .note_idx  (note_idx),
      .note_code (note_code),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Song description, built from the melody text.
   int song_code [N];
   int play_len  [N];
   int song_off  [N+1];
   int song_total;
   int divs [9] = '{0, 382225, 340524, 303372, 286345, 255106, 227272, 202475, 191112};

   task automatic build_song();
      string notes;
      notes = "CCGGAAGFFEEDDCGGFFEEDGGFFEEDCCGGAAGFFEEDDC";
      song_off[0] = 0;
      for (int k = 0; k < N; k++) begin
         case (notes[k])
            "C": song_code[k] = 1;
            "D": song_code[k] = 2;
            "E": song_code[k] = 3;
            "F": song_code[k] = 4;
            "G": song_code[k] = 5;
            "A": song_code[k] = 6;
            default: song_code[k] = 0;
         endcase
         play_len[k]   = ((k % 7) == 6) ? 2 * BEAT : BEAT;
         song_off[k+1] = song_off[k] + play_len[k] + GAP;
      end
      song_total = song_off[N];
   endtask

   // Model state
   bit m_active = 1'b0;
   int m_t      = 0;
   bit m_done   = 1'b0;

   function automatic int entry_of(input int t);
      for (int k = 0; k < N; k++)
         if (t < song_off[k+1]) return k;
      return N - 1;
   endfunction

   task automatic check_outputs();
      int k, pos, d;
      logic exp_tone;
      if (!m_active) begin
         check("busy_idle", 32'(busy), 32'd0);
         check("idx_idle", 32'(note_idx), 32'd0);
         check("code_idle", 32'(note_code), 32'd0);
         check("tone_idle", 32'(tone_out), 32'd0);
      end else begin
         k   = entry_of(m_t);
         pos = m_t - song_off[k];
         check("busy", 32'(busy), 32'd1);
         check("note_idx", 32'(note_idx), 32'(k));
         check("note_code", 32'(note_code), 32'(song_code[k]));
         exp_tone = 1'b0;
         if (pos < play_len[k]) begin
            d = divs[song_code[k]];
            exp_tone = (song_code[k] != 0) && (pos >= 1) && (((pos - 1) % d) < d / 2);
            check("divisor", 32'(dut.u_tone.divisor), 32'(d));
         end
         check("tone_out", 32'(tone_out), 32'(exp_tone));
      end
      check("done", 32'(done), 32'(m_done));
   endtask

   task automatic model_step(input bit r, input bit s, input bit p, input bit l);
      m_done = 1'b0;
      if (r || p) begin
         if (m_active) $display("[%0t] abort by %s at t=%0d", $time, r ? "reset" : "stop", m_t);
         m_active = 1'b0;
      end else if (!m_active) begin
         if (s) begin
            m_active = 1'b1;
            m_t      = 0;
            $display("[%0t] start accepted, playing from entry 0", $time);
         end
      end else if (m_t == song_total - 1) begin
         if (l) begin
            m_t = 0;
            $display("[%0t] song wrapped to entry 0", $time);
         end else begin
            m_active = 1'b0;
            m_done   = 1'b1;
            $display("[%0t] song complete", $time);
         end
      end else begin
         m_t++;
      end
   endtask

   // Called at a falling edge: check this cycle, drive inputs for the next edge.
   task automatic step(input bit r, input bit s, input bit p, input bit l);
      check_outputs();
      start   = s;
      stop    = p;
      loop_en = l;
      if (r) begin
         rst = 1'b1;
         #1;
         m_active = 1'b0;
         m_done   = 1'b0;
         check_outputs();
      end else begin
         rst = 1'b0;
      end
      model_step(r, s, p, l);
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit l, output int dones, output int wraps);
      logic [5:0] prev_idx;
      dones = 0;
      wraps = 0;
      prev_idx = note_idx;
      for (int i = 0; i < n; i++) begin
         if (done === 1'b1) dones++;
         if (busy === 1'b1 && prev_idx == 6'd41 && note_idx == 6'd0) wraps++;
         prev_idx = note_idx;
         step(1'b0, 1'b0, 1'b0, l);
      end
   endtask

   initial begin
      int dones, wraps;
      build_song();

      // Reset state
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // Full song, no loop: exactly one done pulse
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run(song_total + 10, 1'b0, dones, wraps);
      check("done_count", 32'(dones), 32'd1);

      // Looping: wrap 41 -> 0 without done
      step(1'b0, 1'b1, 1'b0, 1'b1);
      run(song_total + 60, 1'b1, dones, wraps);
      check("loop_done_count", 32'(dones), 32'd0);
      check("loop_wraps", 32'(wraps), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Stop mid-PLAY, restart, async reset mid-GAP, restart
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run(7, 1'b0, dones, wraps);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      run(3, 1'b0, dones, wraps);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run(21, 1'b0, dones, wraps);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run(3, 1'b0, dones, wraps);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run(30, 1'b0, dones, wraps);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run(5, 1'b0, dones, wraps);

      // Randomised traffic
      for (int i = 0; i < 8000; i++) begin
         step(($urandom % 900) == 0, ($urandom % 25) == 0,
              ($urandom % 800) == 0, 1'($urandom % 2));
      end
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
